// File: rtl/gaussian_blur_param.sv
// Streaming KSIZE x KSIZE binomial blur between FIFOs, one pixel per cycle, exact shift normalisation.
// Window -> sum stage -> round stage; a full output FIFO freezes the whole pipeline and stops input reads.
module gaussian_blur_param #(
  parameter int WIDTH      = 1280,
  parameter int HEIGHT     = 720,
  parameter int PIXEL_BITS = 8,
  parameter int KSIZE      = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  border_mode,
  output logic                  in_rd_en,
  input  logic                  in_empty,
  input  logic [PIXEL_BITS-1:0] in_dout,
  output logic                  out_wr_en,
  input  logic                  out_full,
  output logic [PIXEL_BITS-1:0] out_din,
  output logic                  frame_done
);

  localparam int R      = KSIZE / 2;
  localparam int S      = 2 * (KSIZE - 1);
  localparam int ACC_W  = PIXEL_BITS + S;
  localparam int HALF   = 1 << (S - 1);
  localparam int FILL_N = R * WIDTH + R;
  localparam int TOTAL  = WIDTH * HEIGHT;
  localparam int STEP_W = $clog2(TOTAL + FILL_N + 1);
  localparam int COL_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  generate
    if (KSIZE != 3 && KSIZE != 5) begin : g_bad_ksize
      $error("gaussian_blur_param: KSIZE must be 3 or 5");
    end
  endgenerate

  function automatic int binom(input int i);
    int b;
    if (KSIZE == 3)            b = (i == 1) ? 2 : 1;
    else if (i == 0 || i == 4) b = 1;
    else if (i == 1 || i == 3) b = 4;
    else                       b = 6;
    return b;
  endfunction

  typedef enum logic [1:0] {FILL, RUN, FLUSH, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [STEP_W-1:0]     step;
  logic [COL_W-1:0]      wcol, ncol, win_col;
  logic [ROW_W-1:0]      nrow, win_row;
  logic [PIXEL_BITS-1:0] lb    [KSIZE-1][WIDTH];
  logic [PIXEL_BITS-1:0] lb_rd [KSIZE-1];
  logic [PIXEL_BITS-1:0] win   [KSIZE][KSIZE];
  logic                  win_vld, win_last, bmode;
  logic [ACC_W-1:0]      acc, s1_sum, rnd;
  logic                  s1_vld, s1_last, s1_bypass;
  logic [PIXEL_BITS-1:0] s1_pix, new_pix;
  logic                  out_valid, out_last;
  logic                  stall, rd_ok, advance, produce, last_step, pipe_empty, on_border;
  logic                  row_ok [KSIZE];
  logic                  col_ok [KSIZE];

  assign stall      = out_valid & out_full;
  assign rd_ok      = (state == FILL || state == RUN) && !in_empty && !stall;
  assign in_rd_en   = rd_ok & ~reset;
  assign advance    = ~reset & (rd_ok | ((state == FLUSH) & ~stall));
  assign produce    = advance & (state != FILL);
  assign new_pix    = (state == FLUSH) ? '0 : in_dout;
  assign last_step  = (step == STEP_W'(TOTAL + FILL_N - 1));
  assign pipe_empty = ~win_vld & ~s1_vld & ~out_valid;
  assign out_wr_en  = out_valid & ~out_full;
  assign frame_done = out_wr_en & out_last;
  assign rnd        = s1_sum + ACC_W'(HALF);

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (advance && step == STEP_W'(FILL_N - 1)) state_nxt = RUN;
      RUN:     if (advance && step == STEP_W'(TOTAL - 1))  state_nxt = FLUSH;
      FLUSH:   if (advance && last_step)                   state_nxt = DRAIN;
      DRAIN:   if (pipe_empty)                             state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // Taps outside the image (including horizontal wrap of the raster stream) are masked to zero.
  always_comb begin
    for (int i = 0; i < KSIZE; i++) begin
      row_ok[i] = (int'(win_row) + i - R >= 0) && (int'(win_row) + i - R < HEIGHT);
      col_ok[i] = (int'(win_col) + i - R >= 0) && (int'(win_col) + i - R < WIDTH);
    end
    on_border = (int'(win_row) < R) || (int'(win_row) >= HEIGHT - R) ||
                (int'(win_col) < R) || (int'(win_col) >= WIDTH - R);
    acc = '0;
    for (int i = 0; i < KSIZE; i++)
      for (int j = 0; j < KSIZE; j++)
        if (row_ok[i] && col_ok[j])
          acc = acc + ACC_W'(binom(i) * binom(j)) * ACC_W'(win[i][j]);
  end

  always_comb begin
    for (int k = 0; k < KSIZE - 1; k++) lb_rd[k] = lb[k][wcol];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= FILL;
      step      <= '0;
      wcol      <= '0;
      ncol      <= '0;
      nrow      <= '0;
      bmode     <= 1'b0;
      win_vld   <= 1'b0;
      win_last  <= 1'b0;
      s1_vld    <= 1'b0;
      s1_last   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_din   <= '0;
    end else begin
      state <= state_nxt;
      if (state == FILL && step == '0) bmode <= border_mode;
      if (state == DRAIN && pipe_empty) begin
        step <= '0;
        wcol <= '0;
        ncol <= '0;
        nrow <= '0;
      end else if (advance) begin
        step <= step + 1'b1;
        wcol <= (wcol == COL_W'(WIDTH - 1)) ? '0 : wcol + 1'b1;
        if (produce) begin
          ncol <= (ncol == COL_W'(WIDTH - 1)) ? '0 : ncol + 1'b1;
          if (ncol == COL_W'(WIDTH - 1)) nrow <= nrow + 1'b1;
        end
      end
      if (!stall) begin
        win_vld  <= produce;
        win_last <= produce & last_step;
        if (produce) begin
          win_row <= nrow;
          win_col <= ncol;
        end
        s1_vld    <= win_vld;
        s1_last   <= win_last;
        s1_sum    <= acc;
        s1_bypass <= bmode & on_border;
        s1_pix    <= win[R][R];
        out_valid <= s1_vld;
        out_last  <= s1_last;
        if (s1_vld) out_din <= s1_bypass ? s1_pix : rnd[S +: PIXEL_BITS];
      end
    end
  end

  // Line buffers chain row to row at the same column; window shifts left, newest column on the right.
  always_ff @(posedge clock) begin
    if (advance) begin
      for (int i = 0; i < KSIZE; i++)
        for (int j = 0; j < KSIZE - 1; j++)
          win[i][j] <= win[i][j+1];
      win[KSIZE-1][KSIZE-1] <= new_pix;
      for (int k = 0; k < KSIZE - 1; k++) win[KSIZE-2-k][KSIZE-1] <= lb_rd[k];
      lb[0][wcol] <= new_pix;
      for (int k = 1; k < KSIZE - 1; k++) lb[k][wcol] <= lb_rd[k-1];
    end
  end

endmodule

// File: tb/tb_gaussian_blur_param.sv
// Bench for gaussian_blur_param: a K3 8x6 and a K5 16x8 instance share one muxed stimulus path,
// outputs are compared against a direct convolution model of the image.
module tb_gaussian_blur_param;

  logic       clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_drv, sel, border_mode, in_empty, out_full;
  logic [7:0] in_dout;
  logic       rst3, rst5, e3, e5;
  logic       rd3, wr3, fd3, rd5, wr5, fd5;
  logic [7:0] din3, din5;
  logic       m_rd, m_wr, m_fd;
  logic [7:0] m_dout;

  assign rst3   = reset_drv | sel;
  assign rst5   = reset_drv | ~sel;
  assign e3     = in_empty | sel;
  assign e5     = in_empty | ~sel;
  assign m_rd   = sel ? rd5 : rd3;
  assign m_wr   = sel ? wr5 : wr3;
  assign m_fd   = sel ? fd5 : fd3;
  assign m_dout = sel ? din5 : din3;

  gaussian_blur_param #(.WIDTH(8), .HEIGHT(6), .PIXEL_BITS(8), .KSIZE(3)) dut3 (
    .clock(clock), .reset(rst3), .border_mode(border_mode),
    .in_rd_en(rd3), .in_empty(e3), .in_dout(in_dout),
    .out_wr_en(wr3), .out_full(out_full), .out_din(din3), .frame_done(fd3));

  gaussian_blur_param #(.WIDTH(16), .HEIGHT(8), .PIXEL_BITS(8), .KSIZE(5)) dut5 (
    .clock(clock), .reset(rst5), .border_mode(border_mode),
    .in_rd_en(rd5), .in_empty(e5), .in_dout(in_dout),
    .out_wr_en(wr5), .out_full(out_full), .out_din(din5), .frame_done(fd5));

  int W, H, K;
  int img [16][16];
  int pix_in[$], exp_out[$], got_out[$], fd_pos[$];
  int first_wr, last_wr;
  int n_checks, n_fail;

  // Direct 2-D convolution with binomial weights C(K-1,i), zero outside the image.
  function automatic int expect_px(input int r, input int c, input int mode);
    int b[5];
    int rr, cc, sum, rad, sh;
    rad = K / 2;
    sh  = 2 * (K - 1);
    b[0] = 1;
    for (int i = 1; i < K; i++) b[i] = b[i-1] * (K - i) / i;
    if (mode != 0 && (r < rad || r >= H - rad || c < rad || c >= W - rad)) return img[r][c];
    sum = 0;
    for (int di = 0; di < K; di++)
      for (int dj = 0; dj < K; dj++) begin
        rr = r + di - rad;
        cc = c + dj - rad;
        if (rr >= 0 && rr < H && cc >= 0 && cc < W) sum += b[di] * b[dj] * img[rr][cc];
      end
    return (sum + (1 << (sh - 1))) >> sh;
  endfunction

  function automatic int get_out(input int i);
    return (i < got_out.size()) ? got_out[i] : -1;
  endfunction

  task automatic add_frame(input int mode);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        pix_in.push_back(img[r][c]);
        exp_out.push_back(expect_px(r, c, mode));
      end
  endtask

  task automatic clear_q();
    pix_in.delete();
    exp_out.delete();
  endtask

  task automatic fill_img(input int kind);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        case (kind)
          0:       img[r][c] = 100;
          1:       img[r][c] = 0;
          2:       img[r][c] = (r * 29 + c * 7) % 256;
          default: img[r][c] = int'($urandom_range(255));
        endcase
  endtask

  task automatic do_reset();
    in_empty  = 1'b1;
    out_full  = 1'b0;
    reset_drv = 1'b1;
    repeat (3) @(negedge clock);
    reset_drv = 1'b0;
  endtask

  task automatic select(input logic s);
    @(negedge clock);
    sel = s;
    W = s ? 16 : 8;
    H = s ? 8 : 6;
    K = s ? 5 : 3;
    do_reset();
  endtask

  task automatic run_stream(input int gap_pct, input int full_pct);
    int ip, op, cyc, extra;
    ip = 0; op = 0; cyc = 0; extra = 0;
    got_out.delete();
    fd_pos.delete();
    first_wr = -1;
    last_wr  = -1;
    while (op < exp_out.size() && cyc < 20000) begin
      @(negedge clock);
      in_empty = (ip >= pix_in.size()) || ($urandom_range(99) < gap_pct);
      in_dout  = (ip < pix_in.size()) ? 8'(pix_in[ip]) : 8'd0;
      out_full = ($urandom_range(99) < full_pct);
      #1;
      if (m_rd) ip++;
      if (m_wr) begin
        got_out.push_back(int'(m_dout));
        op++;
        if (m_fd) fd_pos.push_back(op);
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
      end
      cyc++;
    end
    n_checks++;
    if (op != exp_out.size()) begin
      n_fail++;
      $display("FAIL stream_timeout: got %0d writes, expected %0d", op, exp_out.size());
    end
    in_empty = 1'b1;
    out_full = 1'b0;
    repeat (8) begin
      @(negedge clock);
      #1;
      if (m_wr) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL extra_writes: got %0d, expected 0", extra);
    end
    n_checks++;
    if (ip != pix_in.size()) begin
      n_fail++;
      $display("FAIL input_reads: got %0d, expected %0d", ip, pix_in.size());
    end
  endtask

  task automatic test_reset();
    sel = 1'b1;
    reset_drv = 1'b1;
    in_empty = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    n_checks += 4;
    if (m_rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b, expected 0", m_rd); end
    if (m_wr !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b, expected 0", m_wr); end
    if (m_dout !== 8'd0) begin n_fail++; $display("FAIL reset_din: got %0d, expected 0", m_dout); end
    if (m_fd !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b, expected 0", m_fd); end
    reset_drv = 1'b0;
    in_empty = 1'b1;
    @(negedge clock);
    #1;
    n_checks += 2;
    if (m_wr !== 1'b0) begin n_fail++; $display("FAIL idle_wr_en: got %b, expected 0", m_wr); end
    if (m_dout !== 8'd0) begin n_fail++; $display("FAIL idle_din: got %0d, expected 0", m_dout); end
  endtask

  task automatic test_k3_const();
    select(1'b0);
    fill_img(0);
    border_mode = 1'b0;
    clear_q();
    add_frame(0);
    run_stream(0, 0);
    for (int i = 0; i < exp_out.size(); i++) begin
      n_checks++;
      if (get_out(i) !== exp_out[i]) begin
        n_fail++;
        $display("FAIL k3_const_pix[%0d]: got %0d, expected %0d", i, get_out(i), exp_out[i]);
      end
    end
    n_checks += 5;
    if (get_out(0) !== 56) begin n_fail++; $display("FAIL k3_corner: got %0d, expected 56", get_out(0)); end
    if (get_out(3) !== 75) begin n_fail++; $display("FAIL k3_edge: got %0d, expected 75", get_out(3)); end
    if (get_out(19) !== 100) begin n_fail++; $display("FAIL k3_interior: got %0d, expected 100", get_out(19)); end
    if (got_out.size() !== 48) begin n_fail++; $display("FAIL k3_count: got %0d, expected 48", got_out.size()); end
    if (fd_pos.size() !== 1 || fd_pos[0] !== 48) begin
      n_fail++;
      $display("FAIL k3_frame_done: got %0d pulses (first at %0d), expected 1 at 48",
               fd_pos.size(), (fd_pos.size() > 0) ? fd_pos[0] : -1);
    end
  endtask

  task automatic test_k3_border1();
    fill_img(0);
    border_mode = 1'b1;
    clear_q();
    add_frame(1);
    run_stream(0, 0);
    for (int i = 0; i < 48; i++) begin
      n_checks++;
      if (get_out(i) !== 100) begin
        n_fail++;
        $display("FAIL k3_border1_pix[%0d]: got %0d, expected 100", i, get_out(i));
      end
    end
  endtask

  task automatic test_k5_impulse();
    int tr[6], tc[6], tv[6];
    tr = '{4, 4, 4, 3, 2, 0};
    tc = '{4, 5, 6, 3, 2, 0};
    tv = '{36, 24, 6, 16, 1, 0};
    select(1'b1);
    fill_img(1);
    img[4][4] = 255;
    border_mode = 1'b0;
    clear_q();
    add_frame(0);
    run_stream(0, 0);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (get_out(tr[i] * 16 + tc[i]) !== tv[i]) begin
        n_fail++;
        $display("FAIL k5_impulse(%0d,%0d): got %0d, expected %0d", tr[i], tc[i],
                 get_out(tr[i] * 16 + tc[i]), tv[i]);
      end
    end
    for (int i = 0; i < exp_out.size(); i++) begin
      n_checks++;
      if (get_out(i) !== exp_out[i]) begin
        n_fail++;
        $display("FAIL k5_impulse_pix[%0d]: got %0d, expected %0d", i, get_out(i), exp_out[i]);
      end
    end
  endtask

  task automatic test_k5_const_ramp();
    fill_img(0);
    border_mode = 1'b0;
    clear_q();
    add_frame(0);
    run_stream(0, 0);
    n_checks += 2;
    if (get_out(0) !== 47) begin n_fail++; $display("FAIL k5_corner: got %0d, expected 47", get_out(0)); end
    if (get_out(127) !== 47) begin n_fail++; $display("FAIL k5_corner_last: got %0d, expected 47", get_out(127)); end
    fill_img(2);
    clear_q();
    add_frame(0);
    run_stream(0, 0);
    for (int i = 0; i < exp_out.size(); i++) begin
      n_checks++;
      if (get_out(i) !== exp_out[i]) begin
        n_fail++;
        $display("FAIL k5_ramp_pix[%0d]: got %0d, expected %0d", i, get_out(i), exp_out[i]);
      end
    end
    n_checks++;
    if (last_wr - first_wr !== W * H - 1) begin
      n_fail++;
      $display("FAIL k5_throughput: got span %0d cycles, expected %0d", last_wr - first_wr, W * H - 1);
    end
  endtask

  task automatic test_k5_random_stall();
    for (int m = 0; m < 2; m++) begin
      fill_img(3);
      border_mode = (m != 0);
      clear_q();
      add_frame(m);
      run_stream(30, 30);
      for (int i = 0; i < exp_out.size(); i++) begin
        n_checks++;
        if (get_out(i) !== exp_out[i]) begin
          n_fail++;
          $display("FAIL k5_random_m%0d_pix[%0d]: got %0d, expected %0d", m, i, get_out(i), exp_out[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int pops;
    pops = 0;
    border_mode = 1'b0;
    for (int cyc = 0; cyc < 300 && pops < 50; cyc++) begin
      @(negedge clock);
      in_empty = 1'b0;
      out_full = 1'b0;
      in_dout  = 8'($urandom_range(255));
      #1;
      if (m_rd) pops++;
    end
    n_checks++;
    if (pops != 50) begin n_fail++; $display("FAIL abort_pops: got %0d, expected 50", pops); end
    @(negedge clock);
    reset_drv = 1'b1;
    #1;
    n_checks++;
    if (m_rd !== 1'b0) begin n_fail++; $display("FAIL abort_rd_en: got %b, expected 0", m_rd); end
    @(negedge clock);
    #1;
    n_checks += 3;
    if (m_wr !== 1'b0) begin n_fail++; $display("FAIL abort_wr_en: got %b, expected 0", m_wr); end
    if (m_dout !== 8'd0) begin n_fail++; $display("FAIL abort_din: got %0d, expected 0", m_dout); end
    if (m_fd !== 1'b0) begin n_fail++; $display("FAIL abort_frame_done: got %b, expected 0", m_fd); end
    reset_drv = 1'b0;
    in_empty = 1'b1;
    clear_q();
    fill_img(3);
    add_frame(0);
    fill_img(3);
    add_frame(0);
    run_stream(20, 20);
    for (int i = 0; i < exp_out.size(); i++) begin
      n_checks++;
      if (get_out(i) !== exp_out[i]) begin
        n_fail++;
        $display("FAIL b2b_pix[%0d]: got %0d, expected %0d", i, get_out(i), exp_out[i]);
      end
    end
    n_checks++;
    if (fd_pos.size() !== 2 || fd_pos[0] !== 128 || fd_pos[1] !== 256) begin
      n_fail++;
      $display("FAIL b2b_frame_done: got %0d pulses (at %0d,%0d), expected 2 at 128,256", fd_pos.size(),
               (fd_pos.size() > 0) ? fd_pos[0] : -1, (fd_pos.size() > 1) ? fd_pos[1] : -1);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    sel = 1'b1;
    reset_drv = 1'b1;
    border_mode = 1'b0;
    in_empty = 1'b1;
    out_full = 1'b0;
    in_dout = 8'd0;
    W = 16; H = 8; K = 5;
    test_reset();
    test_k3_const();
    test_k3_border1();
    test_k5_impulse();
    test_k5_const_ramp();
    test_k5_random_stall();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
